// File: rtl/dma_chan_arbiter_if.sv
// Signal bundle between the DMA channel arbiter and its surroundings: peripheral
// DREQ/DACK lines, the CPU HRQ/HLDA hold handshake and the timing-control block.
interface dma_chan_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] DACK;
  logic              HRQ;
  logic              HLDA;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] sw_req;
  logic              rot_pri_en;
  logic              demand_mode;
  logic              xfer_done;
  logic              eop;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  logic [NUM_CH-1:0] tc_status;
  logic [NUM_CH-1:0] tc_clr;

  // Arbiter side.
  modport master (
    input  DREQ, HLDA, mask, sw_req, rot_pri_en, demand_mode, xfer_done, eop, tc_clr,
    output DACK, HRQ, grant_valid, grant_ch, tc_status
  );

  // Peripheral / CPU / timing-control side.
  modport slave (
    output DREQ, HLDA, mask, sw_req, rot_pri_en, demand_mode, xfer_done, eop, tc_clr,
    input  DACK, HRQ, grant_valid, grant_ch, tc_status
  );
endinterface

// File: rtl/dma_chan_arbiter.sv
// Channel priority and bus-hold arbiter: picks one DMA channel, negotiates the bus
// with the CPU through HRQ/HLDA and drives DACK until the transfer ends.
module dma_chan_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = $clog2(NUM_CH),
  parameter bit DREQ_ACT_HIGH = 1'b1,
  parameter bit DACK_ACT_HIGH = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  dma_chan_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD_REQ,
    S_ACTIVE,
    S_RELEASE
  } state_t;

  localparam logic [NUM_CH-1:0] DACK_IDLE = {NUM_CH{~DACK_ACT_HIGH}};

  state_t            r_state;
  state_t            w_state_next;
  logic [NUM_CH-1:0] r_dreq_s1;
  logic [NUM_CH-1:0] r_dreq_s2;
  logic [NUM_CH-1:0] r_swr;
  logic [NUM_CH-1:0] r_tc;
  logic [NUM_CH-1:0] r_dack;
  logic [CH_W-1:0]   r_ptr;
  logic [CH_W-1:0]   r_grant_ch;
  logic              r_rot_mode;
  logic              r_hrq;
  logic              r_grant_valid;

  logic [NUM_CH-1:0] w_hw_req;
  logic [NUM_CH-1:0] w_req;
  logic              w_any_req;
  logic [CH_W-1:0]   w_base;
  logic [CH_W:0]     w_scan_idx;
  logic [CH_W-1:0]   w_winner;
  logic [CH_W-1:0]   w_grant_next;
  logic [CH_W-1:0]   w_ptr_inc;
  logic              w_take_grant;
  logic              w_eop_exit;
  logic              w_normal_exit;
  logic [NUM_CH-1:0] w_eop_vec;
  logic [NUM_CH-1:0] w_dack_onehot;

  assign w_hw_req  = DREQ_ACT_HIGH ? r_dreq_s2 : ~r_dreq_s2;
  assign w_req     = (w_hw_req & ~bus.mask) | r_swr;
  assign w_any_req = |w_req;
  assign w_base    = bus.rot_pri_en ? r_ptr : '0;

  // Scan downward so the first requester at or after w_base (mod NUM_CH) wins.
  always_comb begin
    w_winner   = '0;
    w_scan_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_scan_idx = {1'b0, w_base} + (CH_W + 1)'(k);
      if (w_scan_idx >= (CH_W + 1)'(NUM_CH)) begin
        w_scan_idx = w_scan_idx - (CH_W + 1)'(NUM_CH);
      end
      if (w_req[w_scan_idx[CH_W-1:0]]) begin
        w_winner = w_scan_idx[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant_ch;
    w_take_grant  = 1'b0;
    w_eop_exit    = 1'b0;
    w_normal_exit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_next = S_HOLD_REQ;
      end
      S_HOLD_REQ: begin
        if (bus.HLDA) begin
          if (w_any_req) begin
            w_state_next = S_ACTIVE;
            w_grant_next = w_winner;
            w_take_grant = 1'b1;
          end else begin
            w_state_next = S_RELEASE;
          end
        end
      end
      S_ACTIVE: begin
        // Losing HLDA is a CPU abort: no terminal count, no pointer movement.
        if (!bus.HLDA) begin
          w_state_next = S_IDLE;
        end else if (bus.eop) begin
          w_state_next  = S_RELEASE;
          w_eop_exit    = 1'b1;
          w_normal_exit = 1'b1;
        end else if (bus.xfer_done) begin
          if (!(bus.demand_mode && w_req[r_grant_ch])) begin
            w_state_next  = S_RELEASE;
            w_normal_exit = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (!bus.HLDA) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_eop_vec     = w_eop_exit ? (NUM_CH'(1) << r_grant_ch) : '0;
  assign w_ptr_inc     = (r_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : r_grant_ch + CH_W'(1);
  assign w_dack_onehot = (w_state_next == S_ACTIVE) ? (NUM_CH'(1) << w_grant_next) : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dreq_s1     <= '0;
      r_dreq_s2     <= '0;
      r_swr         <= '0;
      r_tc          <= '0;
      r_dack        <= DACK_IDLE;
      r_ptr         <= '0;
      r_grant_ch    <= '0;
      r_rot_mode    <= 1'b0;
      r_hrq         <= 1'b0;
      r_grant_valid <= 1'b0;
    end else begin
      r_dreq_s1     <= bus.DREQ;
      r_dreq_s2     <= r_dreq_s1;
      r_swr         <= (r_swr & ~w_eop_vec) | bus.sw_req;
      r_tc          <= (r_tc & ~bus.tc_clr) | w_eop_vec;
      r_dack        <= DACK_ACT_HIGH ? w_dack_onehot : ~w_dack_onehot;
      r_grant_ch    <= w_grant_next;
      r_hrq         <= (w_state_next == S_HOLD_REQ) || (w_state_next == S_ACTIVE);
      r_grant_valid <= (w_state_next == S_ACTIVE);
      if (w_take_grant) r_rot_mode <= bus.rot_pri_en;
      if (!bus.rot_pri_en) begin
        r_ptr <= '0;
      end else if (w_normal_exit && r_rot_mode) begin
        r_ptr <= w_ptr_inc;
      end
    end
  end

  assign bus.DACK        = r_dack;
  assign bus.HRQ         = r_hrq;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_ch    = r_grant_ch;
  assign bus.tc_status   = r_tc;

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// Scenario-by-scenario bench for dma_chan_arbiter (4 channels, DREQ active high,
// DACK active low) with a transaction-level priority/terminal-count model.
module tb_dma_chan_arbiter;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dma_chan_arbiter_if #(.NUM_CH(N)) dif ();

  dma_chan_arbiter #(
    .NUM_CH(N), .DREQ_ACT_HIGH(1'b1), .DACK_ACT_HIGH(1'b0)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .bus(dif)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model state.
  int           m_ptr = 0;
  logic [N-1:0] m_swr = '0;
  logic [N-1:0] m_tc  = '0;

  // Search for the first requesting channel starting at 'start', wrapping round.
  function automatic int pick(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (|(req & (N'(1) << j))) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] dack_for(input int ch);
    return ~(N'(1) << ch);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hrq(input int budget, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      if (dif.HRQ === 1'b1) seen = 1'b1;
      else begin
        tick();
        cycles++;
      end
    end
  endtask

  task automatic grant_bus(input int delay);
    repeat (delay) tick();
    dif.HLDA = 1'b1;
    tick();
  endtask

  task automatic end_service(input bit use_eop);
    if (use_eop) dif.eop = 1'b1;
    else dif.xfer_done = 1'b1;
    tick();
    dif.eop = 1'b0;
    dif.xfer_done = 1'b0;
  endtask

  task automatic drop_hlda();
    dif.HLDA = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (dif.DACK !== 4'b1111) begin errors++; $display("FAIL reset_dack: got %b expected 1111", dif.DACK); end
    checks++; if (dif.HRQ !== 1'b0) begin errors++; $display("FAIL reset_hrq: got %b expected 0", dif.HRQ); end
    checks++; if (dif.tc_status !== 4'b0000) begin errors++; $display("FAIL reset_tc: got %b expected 0000", dif.tc_status); end
    checks++; if (dif.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b expected 0", dif.grant_valid); end
    checks++; if (dif.grant_ch !== 2'd0) begin errors++; $display("FAIL reset_gch: got %0d expected 0", dif.grant_ch); end
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (dif.DACK !== 4'b1111) begin errors++; $display("FAIL post_reset_dack: got %b expected 1111", dif.DACK); end
    checks++; if (dif.HRQ !== 1'b0) begin errors++; $display("FAIL post_reset_hrq: got %b expected 0", dif.HRQ); end
    $display("reset: DACK=%b HRQ=%b tc=%b", dif.DACK, dif.HRQ, dif.tc_status);
  endtask

  task automatic test_fixed_priority();
    bit seen;
    int cyc;
    dif.rot_pri_en = 1'b0;
    dif.demand_mode = 1'b0;
    m_ptr = 0;
    dif.DREQ = 4'b1010;
    wait_hrq(20, seen, cyc);
    checks++; if (!seen || cyc != 3) begin errors++; $display("FAIL dreq_to_hrq_latency: got %0d cycles (seen=%0d) expected 3", cyc, seen); end
    grant_bus(2);
    checks++; if (dif.grant_ch !== 2'd1) begin errors++; $display("FAIL fixed_grant: got %0d expected 1", dif.grant_ch); end
    checks++; if (dif.DACK !== dack_for(1)) begin errors++; $display("FAIL fixed_dack: got %b expected %b", dif.DACK, dack_for(1)); end
    checks++; if (dif.grant_valid !== 1'b1) begin errors++; $display("FAIL fixed_gv: got %b expected 1", dif.grant_valid); end
    end_service(1'b0);
    checks++; if (dif.HRQ !== 1'b0 || dif.DACK !== 4'b1111 || dif.grant_valid !== 1'b0) begin
      errors++; $display("FAIL fixed_release: got HRQ=%b DACK=%b gv=%b expected 0/1111/0", dif.HRQ, dif.DACK, dif.grant_valid);
    end
    drop_hlda();
    wait_hrq(20, seen, cyc);
    checks++; if (!seen) begin errors++; $display("FAIL fixed_rerequest: got no HRQ expected HRQ=1"); end
    grant_bus(1);
    checks++; if (dif.grant_ch !== 2'd1) begin errors++; $display("FAIL fixed_regrant: got %0d expected 1", dif.grant_ch); end
    dif.DREQ = '0;
    end_service(1'b0);
    drop_hlda();
    repeat (4) tick();
    checks++; if (dif.HRQ !== 1'b0) begin errors++; $display("FAIL fixed_idle: got HRQ=%b expected 0", dif.HRQ); end
    $display("fixed: two services on ch1");
  endtask

  task automatic test_rotating();
    bit seen;
    int cyc;
    int exp;
    dif.rot_pri_en = 1'b1;
    dif.DREQ = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      wait_hrq(20, seen, cyc);
      checks++; if (!seen) begin errors++; $display("FAIL rot_hrq_%0d: got no HRQ expected HRQ=1", s); end
      grant_bus(1 + s % 2);
      exp = pick(4'b1111, m_ptr);
      checks++; if (dif.grant_ch !== 2'(exp)) begin errors++; $display("FAIL rot_grant_%0d: got %0d expected %0d", s, dif.grant_ch, exp); end
      if (s == 4) dif.DREQ = '0;
      end_service(1'b0);
      checks++; if (dif.HRQ !== 1'b0) begin errors++; $display("FAIL rot_hrq_gap_%0d: got %b expected 0", s, dif.HRQ); end
      m_ptr = (exp + 1) % N;
      drop_hlda();
      $display("rotating service %0d: grant=%0d", s, dif.grant_ch);
    end
    repeat (3) tick();
  endtask

  task automatic test_demand_eop();
    bit seen;
    int cyc;
    dif.rot_pri_en = 1'b0;
    m_ptr = 0;
    dif.demand_mode = 1'b1;
    dif.DREQ = 4'b0100;
    wait_hrq(20, seen, cyc);
    checks++; if (!seen) begin errors++; $display("FAIL demand_hrq: got no HRQ expected HRQ=1"); end
    grant_bus(2);
    checks++; if (dif.grant_ch !== 2'd2) begin errors++; $display("FAIL demand_grant: got %0d expected 2", dif.grant_ch); end
    for (int i = 0; i < 3; i++) begin
      dif.xfer_done = 1'b1;
      tick();
      dif.xfer_done = 1'b0;
      checks++; if (dif.DACK !== 4'b1011 || dif.grant_valid !== 1'b1) begin
        errors++; $display("FAIL demand_hold_%0d: got DACK=%b gv=%b expected 1011/1", i, dif.DACK, dif.grant_valid);
      end
    end
    dif.DREQ = '0;
    end_service(1'b1);
    m_tc = m_tc | 4'b0100;
    checks++; if (dif.tc_status !== m_tc) begin errors++; $display("FAIL demand_tc: got %b expected %b", dif.tc_status, m_tc); end
    checks++; if (dif.HRQ !== 1'b0 || dif.DACK !== 4'b1111) begin errors++; $display("FAIL demand_release: got HRQ=%b DACK=%b expected 0/1111", dif.HRQ, dif.DACK); end
    drop_hlda();
    repeat (3) tick();
    dif.tc_clr = 4'b0100;
    tick();
    dif.tc_clr = '0;
    m_tc = m_tc & ~4'b0100;
    checks++; if (dif.tc_status !== m_tc) begin errors++; $display("FAIL demand_tc_clr: got %b expected %b", dif.tc_status, m_tc); end
    dif.demand_mode = 1'b0;
    $display("demand: ch2 held over 3 transfers, eop tc set and cleared");
  endtask

  task automatic test_mask_swreq();
    bit seen;
    bit hrq_seen;
    int cyc;
    logic [N-1:0] req;
    dif.rot_pri_en = 1'b0;
    dif.mask = 4'b1111;
    dif.DREQ = 4'b1111;
    hrq_seen = 1'b0;
    repeat (10) begin
      tick();
      if (dif.HRQ !== 1'b0) hrq_seen = 1'b1;
    end
    checks++; if (hrq_seen) begin errors++; $display("FAIL mask_blocks: got HRQ=1 expected HRQ=0 for 10 cycles"); end
    dif.sw_req = 4'b1000;
    tick();
    dif.sw_req = '0;
    m_swr = m_swr | 4'b1000;
    wait_hrq(20, seen, cyc);
    checks++; if (!seen) begin errors++; $display("FAIL swreq_hrq: got no HRQ expected HRQ=1"); end
    grant_bus(1);
    req = (4'b1111 & ~4'b1111) | m_swr;
    checks++; if (dif.grant_ch !== 2'(pick(req, 0))) begin errors++; $display("FAIL swreq_grant: got %0d expected %0d", dif.grant_ch, pick(req, 0)); end
    end_service(1'b1);
    m_swr = m_swr & ~4'b1000;
    m_tc = m_tc | 4'b1000;
    checks++; if (dif.tc_status !== m_tc) begin errors++; $display("FAIL swreq_tc: got %b expected %b", dif.tc_status, m_tc); end
    drop_hlda();
    hrq_seen = 1'b0;
    repeat (6) begin
      tick();
      if (dif.HRQ !== 1'b0) hrq_seen = 1'b1;
    end
    checks++; if (hrq_seen) begin errors++; $display("FAIL swreq_cleared: got HRQ=1 expected no request after eop"); end
    dif.DREQ = '0;
    repeat (3) tick();
    dif.mask = '0;
    dif.tc_clr = 4'b1000;
    tick();
    dif.tc_clr = '0;
    m_tc = m_tc & ~4'b1000;
    $display("mask/sw_req: ch3 served by software request, tc=%b", dif.tc_status);
  endtask

  task automatic test_abort();
    bit seen;
    int cyc;
    int exp;
    dif.rot_pri_en = 1'b1;
    dif.DREQ = 4'b0011;
    wait_hrq(20, seen, cyc);
    checks++; if (!seen) begin errors++; $display("FAIL abort_hrq: got no HRQ expected HRQ=1"); end
    grant_bus(1);
    exp = pick(4'b0011, m_ptr);
    checks++; if (dif.grant_ch !== 2'(exp) || dif.DACK !== dack_for(exp)) begin
      errors++; $display("FAIL abort_first_grant: got ch=%0d DACK=%b expected %0d/%b", dif.grant_ch, dif.DACK, exp, dack_for(exp));
    end
    drop_hlda();
    checks++; if (dif.DACK !== 4'b1111 || dif.HRQ !== 1'b0 || dif.grant_valid !== 1'b0) begin
      errors++; $display("FAIL abort_release: got DACK=%b HRQ=%b gv=%b expected 1111/0/0", dif.DACK, dif.HRQ, dif.grant_valid);
    end
    checks++; if (dif.tc_status !== m_tc) begin errors++; $display("FAIL abort_tc: got %b expected %b", dif.tc_status, m_tc); end
    wait_hrq(20, seen, cyc);
    grant_bus(1);
    exp = pick(4'b0011, m_ptr);
    checks++; if (!seen || dif.grant_ch !== 2'(exp)) begin errors++; $display("FAIL abort_ptr_kept: got ch=%0d expected %0d", dif.grant_ch, exp); end
    dif.DREQ = '0;
    end_service(1'b0);
    m_ptr = (exp + 1) % N;
    drop_hlda();
    repeat (3) tick();
    $display("abort: regrant after abort on ch%0d", exp);
  endtask

  task automatic test_random();
    bit seen;
    bit rot;
    bit use_eop;
    int cyc;
    int exp;
    logic [N-1:0] dreq, msk, sw, req, clr;
    for (int t = 0; t < 40; t++) begin
      dreq = N'($urandom);
      msk  = N'($urandom);
      sw   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rot  = 1'($urandom_range(0, 1));
      dif.rot_pri_en = rot;
      if (!rot) m_ptr = 0;
      dif.DREQ = dreq;
      dif.mask = msk;
      dif.sw_req = sw;
      tick();
      dif.sw_req = '0;
      m_swr = m_swr | sw;
      repeat (3) tick();
      req = (dreq & ~msk) | m_swr;
      exp = -1;
      if (req == '0) begin
        checks++; if (dif.HRQ !== 1'b0) begin errors++; $display("FAIL rand_%0d_no_req: got HRQ=%b expected 0", t, dif.HRQ); end
      end else begin
        wait_hrq(10, seen, cyc);
        checks++; if (!seen) begin errors++; $display("FAIL rand_%0d_hrq: got no HRQ expected HRQ=1", t); end
        grant_bus($urandom_range(0, 2));
        exp = pick(req, rot ? m_ptr : 0);
        checks++; if (dif.grant_ch !== 2'(exp) || dif.DACK !== dack_for(exp)) begin
          errors++; $display("FAIL rand_%0d_grant: got ch=%0d DACK=%b expected %0d/%b", t, dif.grant_ch, dif.DACK, exp, dack_for(exp));
        end
        use_eop = 1'($urandom_range(0, 1));
        dif.DREQ = '0;
        end_service(use_eop);
        if (use_eop) begin
          m_tc  = m_tc | (N'(1) << exp);
          m_swr = m_swr & ~(N'(1) << exp);
        end
        if (rot) m_ptr = (exp + 1) % N;
        checks++; if (dif.HRQ !== 1'b0 || dif.tc_status !== m_tc) begin
          errors++; $display("FAIL rand_%0d_end: got HRQ=%b tc=%b expected 0/%b", t, dif.HRQ, dif.tc_status, m_tc);
        end
        drop_hlda();
      end
      if ($urandom_range(0, 3) == 0) begin
        clr = N'($urandom);
        dif.tc_clr = clr;
        tick();
        dif.tc_clr = '0;
        m_tc = m_tc & ~clr;
        checks++; if (dif.tc_status !== m_tc) begin errors++; $display("FAIL rand_%0d_tc_clr: got %b expected %b", t, dif.tc_status, m_tc); end
      end
      dif.DREQ = '0;
      repeat (3) tick();
      $display("txn %0d: dreq=%b mask=%b swr=%b rot=%0d grant=%0d tc=%b", t, dreq, msk, m_swr, rot, exp, dif.tc_status);
    end
  endtask

  initial begin
    dif.DREQ = '0;
    dif.HLDA = 1'b0;
    dif.mask = '0;
    dif.sw_req = '0;
    dif.rot_pri_en = 1'b0;
    dif.demand_mode = 1'b0;
    dif.xfer_done = 1'b0;
    dif.eop = 1'b0;
    dif.tc_clr = '0;
    test_reset();
    test_fixed_priority();
    test_rotating();
    test_demand_eop();
    test_mask_swreq();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
